// File: rtl/smg_scan_ctrl_module_if.sv
// smg_scan_ctrl_module_if: display data, load handshake and digit-drive signals of the scan controller
interface smg_scan_ctrl_module_if;
    logic [23:0] disp_data;
    logic        load_req;
    logic        load_ack;
    logic        lz_en;
    logic [5:0]  blank_mask;
    logic [3:0]  number_data;
    logic [5:0]  smg_sel;
    logic        frame_done;
    modport master (
        output disp_data, load_req, lz_en, blank_mask,
        input  load_ack, number_data, smg_sel, frame_done
    );
    modport slave (
        input  disp_data, load_req, lz_en, blank_mask,
        output load_ack, number_data, smg_sel, frame_done
    );
endinterface

// File: rtl/smg_scan_ctrl_module.sv
// smg_scan_ctrl_module: six-digit 7-segment scanner with dead time, frame-aligned data commit and blanking
module smg_scan_ctrl_module #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 16
) (
    input logic                    CLK,
    input logic                    RST,
    smg_scan_ctrl_module_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV > DEAD_CYC ? SCAN_DIV : DEAD_CYC);
    typedef enum logic {DEAD, SHOW} state_t;
    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [2:0]     idx, idx_nx;
    logic           wrap;
    logic [23:0]    staging, shadow;
    logic           pending;
    logic [5:1]     lz;
    logic [5:0]     blank;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= DEAD;
            cnt           <= '0;
            idx           <= '0;
            staging       <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            bus.load_ack  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            idx            <= idx_nx;
            bus.frame_done <= wrap;
            bus.load_ack   <= wrap && pending;
            if (wrap && pending) shadow <= staging;
            // a strobe on the commit edge re-arms pending for the next frame
            pending        <= bus.load_req || (pending && !wrap);
            if (bus.load_req) staging <= bus.disp_data;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        wrap     = 1'b0;
        if (state == DEAD && cnt == CW'(DEAD_CYC - 1)) begin
            state_nx = SHOW;
            cnt_nx   = '0;
        end else if (state == SHOW && cnt == CW'(SCAN_DIV - 1)) begin
            state_nx = DEAD;
            cnt_nx   = '0;
            wrap     = idx == 3'd5;
            idx_nx   = wrap ? 3'd0 : idx + 3'd1;
        end
    end
    // lz[i]: nibbles i..5 of the displayed value are all zero
    for (genvar i = 1; i < 6; i++) begin : g_lz
        assign lz[i] = shadow[23:4*i] == '0;
    end
    assign blank           = bus.blank_mask | ({lz, 1'b0} & {6{bus.lz_en}});
    assign bus.smg_sel     = (!RST && state == SHOW && !blank[idx]) ? ~(6'd1 << idx) : 6'h3f;
    assign bus.number_data = RST ? 4'd0 : shadow[4*idx +: 4];
endmodule

// File: tb/tb_smg_scan_ctrl_module.sv
// tb_smg_scan_ctrl_module: directed and random scan sequences checked cycle by cycle against a frame-position model
module tb_smg_scan_ctrl_module;
    localparam int SD = 8, DC = 2, SLOT = SD + DC, FRAME = 6 * SLOT;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    smg_scan_ctrl_module_if bus();
    smg_scan_ctrl_module #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
    always #5 CLK = ~CLK;
    int compared = 0, mismatched = 0, t = 0;
    logic [23:0] m_stage = '0, m_shadow = '0;
    logic m_pend = 1'b0, m_ack = 1'b0, m_fd = 1'b0;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h at t=%0d", tag, got, exp, t);
        end
    endtask

    function automatic logic [5:0] exp_sel();
        int p, d;
        bit dark;
        p = t % FRAME;
        d = p / SLOT;
        if (p % SLOT < DC) return 6'h3f;
        dark = bus.blank_mask[d] || (bus.lz_en && d != 0 && (m_shadow >> (4 * d)) == 0);
        return dark ? 6'h3f : ~(6'(1) << d);
    endfunction

    function automatic logic [3:0] exp_num();
        return 4'(m_shadow >> (4 * ((t % FRAME) / SLOT)));
    endfunction

    // called just after a falling edge with inputs already driven for this cycle
    task automatic tick();
        #1;
        chk("smg_sel", 24'(bus.smg_sel), 24'(exp_sel()));
        chk("number_data", 24'(bus.number_data), 24'(exp_num()));
        chk("load_ack", 24'(bus.load_ack), 24'(m_ack));
        chk("frame_done", 24'(bus.frame_done), 24'(m_fd));
        m_fd  = t % FRAME == FRAME - 1;
        m_ack = m_fd && m_pend;
        if (m_ack) begin
            m_shadow = m_stage;
            m_pend   = 1'b0;
        end
        if (bus.load_req) begin
            m_stage = bus.disp_data;
            m_pend  = 1'b1;
        end
        t++;
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && t % FRAME != pos; i++) tick();
    endtask

    task automatic load(input logic [23:0] d);
        bus.disp_data = d;
        bus.load_req  = 1'b1;
        tick();
        bus.load_req  = 1'b0;
    endtask

    task automatic show(input logic [23:0] d);
        load(d);
        run_to(FRAME - 1);
        run(FRAME + 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.load_req = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_smg_sel", 24'(bus.smg_sel), 24'h3f);
        chk("rst_number_data", 24'(bus.number_data), 24'h0);
        chk("rst_load_ack", 24'(bus.load_ack), 24'h0);
        chk("rst_frame_done", 24'(bus.frame_done), 24'h0);
        @(negedge CLK);
        RST = 1'b0;
        t = 0;
        m_stage = '0;
        m_shadow = '0;
        m_pend = 1'b0;
        m_ack = 1'b0;
        m_fd = 1'b0;
    endtask

    function automatic logic [23:0] rand_data();
        logic [23:0] v;
        v = 24'($urandom);
        return v >> (4 * $urandom_range(0, 6));
    endfunction

    initial begin
        bus.disp_data  = '0;
        bus.load_req   = 1'b0;
        bus.lz_en      = 1'b0;
        bus.blank_mask = '0;
        do_reset();
        run(2 * FRAME + 5);
        run_to(25);
        show(24'h543210);
        bus.lz_en = 1'b1;
        show(24'h000070);
        show(24'h000000);
        bus.lz_en = 1'b0;
        bus.blank_mask = 6'b000101;
        show(24'h999999);
        bus.blank_mask = '0;
        run_to(17);
        load(24'h222222);
        run_to(FRAME - 1);
        load(24'h111111);
        run(2 * FRAME);
        repeat (700) begin
            bus.lz_en = 1'($urandom_range(0, 1));
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            if ($urandom_range(0, 30) == 0) load(rand_data());
            else if ($urandom_range(0, 60) == 0) begin
                run_to(FRAME - 1);
                load(rand_data());
            end else tick();
        end
        bus.lz_en = 1'b0;
        bus.blank_mask = '0;
        load(24'h333333);
        run_to(3 * SLOT + DC + 3);
        do_reset();
        run(2 * FRAME + 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/smg_scan_ctrl_module.md
SMG_SCAN_CTRL_MODULE -- requirements
Module: smg_scan_ctrl_module

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning the number of cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have parameter DEAD_CYC, default 16, meaning the number of all-off cycles between digits (legal range 1..255).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port disp_data  input  24  six 4-bit digit codes; [3:0] is digit 0, [23:20] is digit 5 (most significant).
REQ-006 SHALL have port load_req  input  1  single-cycle strobe that captures disp_data.
REQ-007 SHALL have port load_ack  output  1  single-cycle pulse when captured data becomes visible.
REQ-008 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-009 SHALL have port blank_mask  input  6  bit i=1 forces digit i dark.
REQ-010 SHALL have port number_data  output  4  code to the 7-segment encoder (one-cycle encoder latency).
REQ-011 SHALL have port smg_sel  output  6  digit selects, active-low; bit i selects digit i.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse at the end of each six-digit frame.

Function
REQ-013 SHALL hold a staging register, a pending flag, a shadow register (displayed value), digit index idx (0..5), a cycle counter cnt and a state in {DEAD, SHOW}.
REQ-014 On load_req=1, SHALL capture disp_data into the staging register and set pending=1; a later load_req before commit SHALL overwrite the staging register (last write wins).
REQ-015 DEAD state: smg_sel=6'b111111; cnt counts 0..DEAD_CYC-1; at DEAD_CYC-1 SHALL go to SHOW with cnt=0.
REQ-016 number_data SHALL equal shadow nibble idx throughout DEAD and SHOW, updated on the cycle DEAD is entered; the encoder output is therefore settled before SHOW.
REQ-017 SHOW state: smg_sel[idx]=0 and all other bits 1, unless digit idx is blanked (REQ-019), in which case smg_sel=6'b111111; lasts exactly SCAN_DIV cycles (cnt 0..SCAN_DIV-1).
REQ-018 At SHOW with cnt=SCAN_DIV-1, SHALL go to DEAD with cnt=0 and idx=idx+1, wrapping from 5 to 0.
REQ-019 Digit i SHALL be blanked if blank_mask[i]=1, or if lz_en=1, i!=0, and shadow nibbles i..5 are all zero; digit 0 is never blanked by lz_en.
REQ-020 On the 5->0 wrap, SHALL pulse frame_done=1 for one cycle; on the same edge, if pending=1, SHALL copy staging to shadow, clear pending, and pulse load_ack=1 for one cycle.
REQ-021 When load_req coincides with a commit edge, the commit SHALL use the old staging value; staging SHALL take the new data and pending SHALL remain 1, so the new data commits at the next frame boundary.
REQ-022 Shadow SHALL never change mid-frame; digit 0's number_data after the wrap SHALL reflect the newly committed shadow.
REQ-023 lz_en and blank_mask SHALL be sampled combinationally each SHOW cycle; no latching.
REQ-024 One frame SHALL be exactly 6*(SCAN_DIV+DEAD_CYC) cycles.

Reset
REQ-025 While RST=1, SHALL set state=DEAD, idx=0, cnt=0, staging=0, shadow=0, pending=0, smg_sel=6'b111111, number_data=0, load_ack=0, frame_done=0.
REQ-026 Reset asserted mid-SHOW or mid-commit SHALL discard staged data; the first SHOW after release SHALL begin DEAD_CYC cycles after RST falls, on digit 0.

Verification (SCAN_DIV=8, DEAD_CYC=2)
REQ-027 Release reset, no load -> smg_sel=111111 for 2 cycles, then 111110 for 8 cycles with number_data=0, then 2 off cycles, then 111101; frame_done pulses every 60 cycles.
REQ-028 load_req with disp_data=24'h543210 mid-frame -> no shadow change until wrap; load_ack and frame_done pulse together; the next frame shows digits 0..5 as 0,1,2,3,4,5.
REQ-029 disp_data=24'h000070, lz_en=1 -> digits 5,4,3,2 dark (smg_sel=111111 in their SHOW), digits 1 and 0 lit with codes 7 and 0; disp_data=0 -> only digit 0 lit.
REQ-030 blank_mask=6'b000101 with data 24'h999999 -> digits 0 and 2 never selected; the others are selected with code 9.
REQ-031 load_req (24'h111111) on the exact wrap edge while pending 24'h222222 -> 222222 commits with load_ack; 111111 commits at the following wrap with a second load_ack.
REQ-032 RST pulsed during digit 3 SHOW with pending data -> outputs return to reset values the next cycle; after release digit 0 shows 0 and no load_ack occurs.
